// File: rtl/stereo_sample_fifo.sv
// Two independent 16-bit sample FIFOs (left/right) for a codec datapath, each gated by a prefill threshold.
// Head sample is registered and valid in the pop cycle; writes to a full FIFO are dropped, pops while empty return zero.

// One channel: circular buffer with PRIME/STREAM gating and sticky flags.
// RD data comes from a registered head; next head is precomputed from post-edge pointers.
module stereo_sample_fifo_chan #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [15:0]           i_wr_data,
  input  logic                  i_rd,
  input  logic                  i_clr,
  output logic [15:0]           o_rd_data,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_ovf,
  output logic                  o_udf
);
  localparam int AW = DEPTH_LOG2;
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] C_DEPTH   = LW'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] C_PREFILL = LW'(PREFILL);

  typedef enum logic {PRIME, STREAM} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_mem [2**DEPTH_LOG2];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW-1:0]         w_rptr_nxt;
  logic [DEPTH_LOG2:0]   r_level;
  logic [DEPTH_LOG2:0]   w_level_popped;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic [15:0]           r_rd_data;
  logic [15:0]           w_head_nxt;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;

  always_comb begin
    w_pop          = (r_state == STREAM) && i_rd && (r_level != '0);
    w_udf_evt      = (r_state == STREAM) && i_rd && (r_level == '0);
    w_push         = i_wr && ((r_level != C_DEPTH) || w_pop);
    w_ovf_evt      = i_wr && (r_level == C_DEPTH) && !w_pop;
    w_level_popped = r_level - LW'(w_pop);
    w_level_nxt    = w_level_popped + LW'(w_push);
    w_rptr_nxt     = r_rptr + AW'(w_pop);

    w_state_nxt = r_state;
    if (r_state == STREAM) begin
      if (w_udf_evt) w_state_nxt = PRIME;
    end else if (w_level_nxt >= C_PREFILL) begin
      w_state_nxt = STREAM;
    end

    // A sample written into an empty buffer is the new head; it is not in r_mem yet.
    w_head_nxt = 16'h0000;
    if ((w_state_nxt == STREAM) && (w_level_nxt != '0)) begin
      w_head_nxt = (w_level_popped == '0) ? i_wr_data : r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= PRIME;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_rd_data <= 16'h0000;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wptr    <= r_wptr + AW'(w_push);
      r_rptr    <= w_rptr_nxt;
      r_level   <= w_level_nxt;
      r_rd_data <= w_head_nxt;
      r_ovf     <= w_ovf_evt || (r_ovf && !i_clr);
      r_udf     <= w_udf_evt || (r_udf && !i_clr);
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_level   = r_level;
  assign o_ovf     = r_ovf;
  assign o_udf     = r_udf;
endmodule

// Stereo wrapper: two channels sharing only clock, reset and the flag clear.
// Per-channel latency and overflow/underflow behaviour are those of stereo_sample_fifo_chan.
module stereo_sample_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PREFILL    = 8
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  input  logic                  WR_LEFT,
  input  logic [15:0]           WR_DATA_LEFT,
  input  logic                  WR_RIGHT,
  input  logic [15:0]           WR_DATA_RIGHT,
  input  logic                  RD_LEFT,
  output logic [15:0]           RD_DATA_LEFT,
  input  logic                  RD_RIGHT,
  output logic [15:0]           RD_DATA_RIGHT,
  output logic [DEPTH_LOG2:0]   LEVEL_LEFT,
  output logic [DEPTH_LOG2:0]   LEVEL_RIGHT,
  output logic                  OVERFLOW_LEFT,
  output logic                  OVERFLOW_RIGHT,
  output logic                  UNDERFLOW_LEFT,
  output logic                  UNDERFLOW_RIGHT,
  input  logic                  CLR_FLAGS
);
  stereo_sample_fifo_chan #(.DEPTH_LOG2(DEPTH_LOG2), .PREFILL(PREFILL)) u_left (
    .i_clk(MCLK), .i_rst(RESET), .i_wr(WR_LEFT), .i_wr_data(WR_DATA_LEFT),
    .i_rd(RD_LEFT), .i_clr(CLR_FLAGS), .o_rd_data(RD_DATA_LEFT),
    .o_level(LEVEL_LEFT), .o_ovf(OVERFLOW_LEFT), .o_udf(UNDERFLOW_LEFT)
  );

  stereo_sample_fifo_chan #(.DEPTH_LOG2(DEPTH_LOG2), .PREFILL(PREFILL)) u_right (
    .i_clk(MCLK), .i_rst(RESET), .i_wr(WR_RIGHT), .i_wr_data(WR_DATA_RIGHT),
    .i_rd(RD_RIGHT), .i_clr(CLR_FLAGS), .o_rd_data(RD_DATA_RIGHT),
    .o_level(LEVEL_RIGHT), .o_ovf(OVERFLOW_RIGHT), .o_udf(UNDERFLOW_RIGHT)
  );
endmodule

// File: doc/stereo_sample_fifo.md
STEREO_SAMPLE_FIFO -- requirements
Module: stereo_sample_fifo

Interface
REQ-001 The block SHALL have the parameter DEPTH_LOG2, default 4, meaning log2 of entries per channel (16 entries).
REQ-002 The block SHALL have the parameter PREFILL, default 8, meaning the per-channel fill level needed to leave PRIME; legal range 1..2**DEPTH_LOG2.
REQ-003 MCLK  in  1  sole clock; all state SHALL update on posedge MCLK.
REQ-004 RESET  in  1  reset, asynchronous and active-high.
REQ-005 WR_LEFT  in  1  one-cycle write strobe, left channel (ADC side).
REQ-006 WR_DATA_LEFT  in  16  left sample, captured when WR_LEFT=1.
REQ-007 WR_RIGHT  in  1  one-cycle write strobe, right channel.
REQ-008 WR_DATA_RIGHT  in  16  right sample, captured when WR_RIGHT=1.
REQ-009 RD_LEFT  in  1  one-cycle pop request, left channel (DAC side).
REQ-010 RD_DATA_LEFT  out  16  left head sample, valid in the same cycle as RD_LEFT.
REQ-011 RD_RIGHT  in  1  one-cycle pop request, right channel.
REQ-012 RD_DATA_RIGHT  out  16  right head sample, valid in the same cycle as RD_RIGHT.
REQ-013 LEVEL_LEFT / LEVEL_RIGHT  out  DEPTH_LOG2+1 each  stored-entry count per channel.
REQ-014 OVERFLOW_LEFT / OVERFLOW_RIGHT  out  1 each  sticky overflow flag.
REQ-015 UNDERFLOW_LEFT / UNDERFLOW_RIGHT  out  1 each  sticky underflow flag.
REQ-016 CLR_FLAGS  in  1  synchronous clear of all four sticky flags.

Function
REQ-017 Each channel SHALL be an independent circular FIFO of 2**DEPTH_LOG2 x 16-bit entries with wrapping read/write pointers; the two channels SHALL share no state except CLR_FLAGS.
REQ-018 Each channel SHALL run a two-state FSM: PRIME and STREAM.
REQ-019 PRIME: RD_DATA_x SHALL be 16'h0000; RD_x SHALL be ignored (no pop, no flag); PRIME->STREAM on the edge where the post-update level >= PREFILL.
REQ-020 STREAM: RD_DATA_x SHALL equal the oldest stored entry, driven from registered state only (no combinational path from RD_x or WR_x to RD_DATA_x).
REQ-021 STREAM with RD_x=1 and level>0: the head SHALL be popped on that edge and the next entry presented the following cycle.
REQ-022 STREAM with RD_x=1 and level==0: RD_DATA_x SHALL read 16'h0000, UNDERFLOW_x SHALL set, and FSM SHALL return to PRIME.
REQ-023 WR_x=1 with level < depth: the sample SHALL be stored and level incremented.
REQ-024 WR_x=1 with level==depth and no accepted pop that cycle: the sample SHALL be discarded, contents unchanged, OVERFLOW_x set.
REQ-025 Full, STREAM, WR_x and RD_x together: the pop and the write SHALL both complete, and the level SHALL stay at depth.
REQ-026 Empty, STREAM, WR_x and RD_x together: underflow per REQ-022 (no write-through bypass); the write SHALL be stored, level->1, FSM->PRIME.
REQ-027 Sticky flags SHALL remain set until CLR_FLAGS or reset; if CLR_FLAGS coincides with a new flag event, the event SHALL win (flag stays 1).
REQ-028 LEVEL_x SHALL be registered and reflect the count after the most recent edge; range 0..2**DEPTH_LOG2.

Reset
REQ-029 On RESET=1, the block SHALL immediately, without waiting for MCLK, set pointers and levels to 0, all flags to 0, both FSMs to PRIME, and RD_DATA_x to 16'h0000.
REQ-030 Storage array contents need not be cleared; the read-back value of unwritten entries SHALL never be visible at RD_DATA_x.
REQ-031 RESET asserted mid-stream SHALL discard all buffered samples; after release, each channel SHALL re-prime from empty.

Verification
REQ-032 Prime: 7 left writes, 0x0001..0x0007, then RD_LEFT -> RD_DATA_LEFT=0x0000, LEVEL_LEFT stays 7; 8th write (0x0008) -> STREAM; next RD_LEFT sees 0x0001, then 0x0002.
REQ-033 Overflow: 17 right writes, 0x0100..0x0110, no reads -> LEVEL_RIGHT=16, OVERFLOW_RIGHT=1; drain yields 0x0100..0x010F; 0x0110 never appears.
REQ-034 Underflow: STREAM with LEVEL_LEFT=1, two RD_LEFT -> first returns the sample; second returns 0x0000, UNDERFLOW_LEFT=1, FSM PRIME; CLR_FLAGS -> UNDERFLOW_LEFT=0.
REQ-035 Full plus simultaneous WR_LEFT/RD_LEFT -> LEVEL_LEFT stays 16, no OVERFLOW_LEFT, pointer wrap verified over 40 cycles of the same traffic.
REQ-036 Codec cadence: interleaved L/R write strobes every 256 cycles and read requests offset by 128 cycles over 1000 frames -> bit-exact per-channel order, no flags set.
REQ-037 Asynchronous RESET pulse between MCLK edges while LEVEL=10 -> outputs zero before the next edge; subsequent behaviour matches REQ-032.
